// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: state encoding, table/key sizes and key byte selection.
package rc4_pkg;

   localparam int S_SIZE    = 256;
   localparam int KEY_BYTES = 3;

   // bit0 drives the S RAM write enable, bit3 is the finished flag.
   typedef enum logic [7:0] {
      AWAIT_START = 8'h00,
      INIT        = 8'h11,
      READ_SI     = 8'h20,
      COMPUTE_J   = 8'h40,
      READ_SJ     = 8'h60,
      WRITE_SI    = 8'h81,
      WRITE_SJ    = 8'hA1,
      FINISHED    = 8'h08
   } state_t;

   // Byte 0 of the key is the most significant byte.
   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                           input logic [1:0] kidx);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (kidx == k[1:0]) b = key[8*KEY_BYTES-1-8*k -: 8];
      end
      return b;
   endfunction

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector: one-cycle pulse when level goes from low to high.
module trap_edge (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/key_scheduler.sv
// RC4 key-scheduling (KSA) over a shared synchronous-read S RAM.
// Define KSA_DEBUG_TAPS_EN to expose iTap/jTap/stateTap/wrenTap.
module key_scheduler
   import rc4_pkg::*;
#(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_LENGTH = 8,
   parameter int KEY_LENGTH = 3,
   parameter int KEY_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [KEY_WIDTH-1:0]  secret_key,
   input  logic [RAM_WIDTH-1:0]  sOut,
   output logic [RAM_WIDTH-1:0]  sIn,
   output logic [RAM_LENGTH-1:0] sAddr,
   output logic                  sWren,
`ifdef KSA_DEBUG_TAPS_EN
   output logic [7:0]            iTap,
   output logic [7:0]            jTap,
   output logic [7:0]            stateTap,
   output logic                  wrenTap,
`endif
   output logic                  finished
);

   state_t                state, state_next;
   logic [RAM_LENGTH-1:0] i, j, j_new;
   logic [RAM_WIDTH-1:0]  si, sj;
   logic [1:0]            kidx;
   logic [KEY_WIDTH-1:0]  key_q;
   logic                  start_sig;
   logic                  launch;

   trap_edge u_start_edge (
      .clk   (clk),
      .reset (reset),
      .level (start),
      .pulse (start_sig)
   );

   assign launch = start_sig && (state == AWAIT_START || state == FINISHED);
   assign j_new  = j + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte(key_q, kidx));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= AWAIT_START;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      sAddr      = '0;
      sIn        = '0;
      case (state)
         AWAIT_START: if (start_sig) state_next = INIT;
         INIT: begin
            sAddr = i;
            sIn   = RAM_WIDTH'(i);
            if (i == '1) state_next = READ_SI;
         end
         READ_SI: begin
            sAddr      = i;
            state_next = COMPUTE_J;
         end
         COMPUTE_J: begin
            // Address S[j] with the updated j so its data lands in READ_SJ.
            sAddr      = j_new;
            state_next = READ_SJ;
         end
         READ_SJ: state_next = WRITE_SI;
         WRITE_SI: begin
            sAddr      = i;
            sIn        = sj;
            state_next = WRITE_SJ;
         end
         WRITE_SJ: begin
            sAddr      = j;
            sIn        = si;
            state_next = (i == '1) ? FINISHED : READ_SI;
         end
         FINISHED: if (start_sig) state_next = INIT;
         default:  state_next = AWAIT_START;
      endcase
   end

   assign sWren    = state[0];
   assign finished = state[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i     <= '0;
         j     <= '0;
         kidx  <= '0;
         si    <= '0;
         sj    <= '0;
         key_q <= '0;
      end else if (launch) begin
         key_q <= secret_key;
         i     <= '0;
         j     <= '0;
         kidx  <= '0;
      end else begin
         case (state)
            INIT: i <= i + 1'b1;
            COMPUTE_J: begin
               si <= sOut;
               j  <= j_new;
            end
            READ_SJ: sj <= sOut;
            WRITE_SJ: begin
               i    <= i + 1'b1;
               kidx <= (kidx == 2'(KEY_LENGTH - 1)) ? 2'd0 : kidx + 2'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef KSA_DEBUG_TAPS_EN
   assign iTap     = 8'(i);
   assign jTap     = 8'(j);
   assign stateTap = state;
   assign wrenTap  = sWren;
`endif

endmodule
